// File: rtl/comp_iter.sv
// Multi-cycle magnitude comparator: walks the operands MSB chunk first, DIGIT bits
// per cycle, and stops on the first differing chunk. Also returns max/min operand.
module comp_iter #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             is_signed,
  output logic             valid_out,
  output logic             busy,
  output logic             GT,
  output logic             LT,
  output logic             ET,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || N < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "comp_iter: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ka;
  logic [WIDTH-1:0] r_kb;
  logic [IW-1:0]    r_idx;
  logic             r_valid;
  logic             r_gt;
  logic             r_lt;
  logic             r_et;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;

  logic                      w_accept;
  logic                      w_done;
  logic                      w_last;
  logic [WIDTH-1:0]          w_sign_mask;
  logic [0:N-1][DIGIT-1:0]   w_ka_ch;
  logic [0:N-1][DIGIT-1:0]   w_kb_ch;
  logic [DIGIT-1:0]          w_ca;
  logic [DIGIT-1:0]          w_cb;

  // Ascending chunk index puts chunk 0 on the MSBs, matching the compare order.
  assign w_ka_ch     = r_ka;
  assign w_kb_ch     = r_kb;
  assign w_ca        = w_ka_ch[r_idx];
  assign w_cb        = w_kb_ch[r_idx];
  assign w_last      = (r_idx == IW'(N - 1));
  assign w_sign_mask = WIDTH'(is_signed) << (WIDTH - 1);

  assign ready     = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state == S_BUSY);
  assign valid_out = r_valid;
  assign GT        = r_gt;
  assign LT        = r_lt;
  assign ET        = r_et;
  assign max_out   = r_max;
  assign min_out   = r_min;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if ((w_ca != w_cb) || w_last) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_et    <= 1'b0;
      r_max   <= '0;
      r_min   <= '0;
    end else begin
      r_valid <= w_done;
      if (w_accept) begin
        r_idx <= '0;
      end else if (busy && !w_done) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_done) begin
        r_gt  <= (w_ca > w_cb);
        r_lt  <= (w_ca < w_cb);
        r_et  <= (w_ca == w_cb);
        r_max <= (w_ca < w_cb) ? r_b : r_a;
        r_min <= (w_ca < w_cb) ? r_a : r_b;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
  // Flipping the sign bit turns two's-complement order into plain unsigned order.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= in0;
      r_b  <= in1;
      r_ka <= in0 ^ w_sign_mask;
      r_kb <= in1 ^ w_sign_mask;
    end
  end

endmodule

// File: tb/tb_comp_iter.sv
// Scoreboard bench for comp_iter: three configurations (16/4, 32/8, 8/8), directed
// cases plus a random sweep checked against an arithmetic reference model.
module tb_comp_iter;

  typedef struct {
    logic        gt;
    logic        lt;
    logic        et;
    logic [31:0] mx;
    logic [31:0] mn;
    int          lat;
    int          issue;
  } exp_t;

  localparam int W [3] = '{16, 32, 8};
  localparam int D [3] = '{4, 8, 8};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [2:0]  sg_v = '0;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];

  wire  [2:0]  rdy_v, val_v, bsy_v, gt_v, lt_v, et_v;
  wire  [15:0] mx0, mn0;
  wire  [31:0] mx1, mn1;
  wire  [7:0]  mx2, mn2;
  wire  [31:0] mx_v [3];
  wire  [31:0] mn_v [3];

  assign mx_v[0] = {16'b0, mx0};
  assign mn_v[0] = {16'b0, mn0};
  assign mx_v[1] = mx1;
  assign mn_v[1] = mn1;
  assign mx_v[2] = {24'b0, mx2};
  assign mn_v[2] = {24'b0, mn2};

  comp_iter #(.WIDTH(16), .DIGIT(4)) u_w16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .ready(rdy_v[0]),
    .in0(a_v[0][15:0]), .in1(b_v[0][15:0]), .is_signed(sg_v[0]),
    .valid_out(val_v[0]), .busy(bsy_v[0]), .GT(gt_v[0]), .LT(lt_v[0]), .ET(et_v[0]),
    .max_out(mx0), .min_out(mn0));

  comp_iter #(.WIDTH(32), .DIGIT(8)) u_w32 (
    .clk(clk), .rst(rst), .start(start_v[1]), .ready(rdy_v[1]),
    .in0(a_v[1]), .in1(b_v[1]), .is_signed(sg_v[1]),
    .valid_out(val_v[1]), .busy(bsy_v[1]), .GT(gt_v[1]), .LT(lt_v[1]), .ET(et_v[1]),
    .max_out(mx1), .min_out(mn1));

  comp_iter #(.WIDTH(8), .DIGIT(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .ready(rdy_v[2]),
    .in0(a_v[2][7:0]), .in1(b_v[2][7:0]), .is_signed(sg_v[2]),
    .valid_out(val_v[2]), .busy(bsy_v[2]), .GT(gt_v[2]), .LT(lt_v[2]), .ET(et_v[2]),
    .max_out(mx2), .min_out(mn2));

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_q = 1'b1;
  bit   mon_en = 1'b0;
  exp_t sb_q [3][$];
  exp_t last [3];

  always @(posedge clk) begin
    cyc   = cyc + 1;
    rst_q = rst;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain integer ordering; the first differing chunk follows from the
  // highest bit where the operands differ (sign-bit inversion leaves that unchanged).
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sg, input int w, input int d);
    exp_t        e;
    longint      sa = longint'(a);
    longint      sb = longint'(b);
    logic [31:0] x  = a ^ b;
    int          p  = -1;
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    e.gt = (sa > sb);
    e.lt = (sa < sb);
    e.et = (sa == sb);
    e.mx = (sa < sb) ? b : a;
    e.mn = (sa < sb) ? a : b;
    for (int i = w - 1; i >= 0; i--) begin
      if (x[i] && p < 0) p = i;
    end
    e.lat   = (p < 0) ? (w / d) : ((w - 1 - p) / d + 1);
    e.issue = 0;
    return e;
  endfunction

  function automatic logic [95:0] pack_dut(input int k);
    return {29'b0, gt_v[k], lt_v[k], et_v[k], mx_v[k], mn_v[k]};
  endfunction

  function automatic logic [95:0] pack_exp(input exp_t e);
    return {29'b0, e.gt, e.lt, e.et, e.mx, e.mn};
  endfunction

  // Monitor: pops one expectation per valid_out strobe; otherwise results must hold.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (rst_q) last[k] = '{default: 0};
        if (rst) check($sformatf("ready_in_rst%0d", k), 96'(rdy_v[k]), 96'd0);
        if (val_v[k]) begin
          if (sb_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid%0d: got valid_out=1 expected 0 (cycle %0d)", k, cyc);
          end else begin
            e = sb_q[k].pop_front();
            check($sformatf("result%0d", k), pack_dut(k), pack_exp(e));
            check($sformatf("latency%0d", k), 96'(cyc - e.issue), 96'(e.lat));
            last[k] = e;
          end
        end else begin
          check($sformatf("hold%0d", k), pack_dut(k), pack_exp(last[k]));
        end
      end
    end
  end

  // Called at a negedge; scrambles the operand inputs after acceptance.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input bit keep, input bit track);
    int          n = 0;
    logic [31:0] m = mask_of(W[k]);
    exp_t        e;
    while (!rdy_v[k]) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout%0d: ready stayed 0 expected 1", k);
        start_v[k] = 1'b0;
        return;
      end
    end
    a_v[k]     = a & m;
    b_v[k]     = b & m;
    sg_v[k]    = sg;
    start_v[k] = 1'b1;
    if (track) begin
      e       = model(a & m, b & m, sg, W[k], D[k]);
      e.issue = cyc + 1;
      sb_q[k].push_back(e);
    end
    @(negedge clk);
    start_v[k] = keep;
    a_v[k]     = $urandom;
    b_v[k]     = $urandom;
    sg_v[k]    = 1'($urandom);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (sb_q[k].size() != 0 || !rdy_v[k]) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL done_timeout%0d: %0d results still pending expected 0", k, sb_q[k].size());
        sb_q[k].delete();
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      a_v[k]  = '0;
      b_v[k]  = '0;
      last[k] = '{default: 0};
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_outputs%0d", k), pack_dut(k), 96'd0);
      check($sformatf("reset_flags%0d", k), 96'({rdy_v[k], val_v[k], bsy_v[k]}), 96'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 96'({rdy_v[0], bsy_v[0]}), 96'b10);
    mon_en = 1'b1;

    // Directed cases on the 16/4 instance.
    issue(0, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b1); wait_idle(0);
    issue(0, 32'h8000, 32'h7FFF, 1'b0, 1'b0, 1'b1); wait_idle(0);
    issue(0, 32'h8000, 32'h7FFF, 1'b1, 1'b0, 1'b1); wait_idle(0);
    issue(0, 32'hFFFE, 32'hFFFF, 1'b1, 1'b0, 1'b1); wait_idle(0);
    issue(0, 32'h0000, 32'hFFFF, 1'b1, 1'b0, 1'b1); wait_idle(0);

    // Back-to-back with start held high and operands scrambled while busy.
    issue(0, 32'd5, 32'd3, 1'b0, 1'b1, 1'b1);
    issue(0, 32'd3, 32'd5, 1'b0, 1'b1, 1'b1);
    issue(0, 32'd7, 32'd7, 1'b0, 1'b0, 1'b1);
    wait_idle(0);

    // Reset on the second busy cycle: the compare is abandoned with no strobe.
    issue(0, 32'h0001, 32'h0002, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", 96'({rdy_v[0], bsy_v[0], val_v[0]}), 96'b100);
    check("outputs_after_abort", pack_dut(0), 96'd0);
    issue(0, 32'hABCD, 32'hABC0, 1'b1, 1'b0, 1'b1); wait_idle(0);

    // Random sweep over all three configurations.
    for (int k = 0; k < 3; k++) begin
      for (int it = 0; it < 150; it++) begin
        logic [31:0] a = $urandom;
        logic [31:0] b;
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = $urandom;
          2:       b = a ^ (32'd1 << $urandom_range(0, W[k] - 1));
          default: b = a ^ (32'd1 << (W[k] - 1));
        endcase
        issue(k, a, b, 1'($urandom), (it != 149) && ($urandom_range(0, 1) == 1), 1'b1);
      end
      start_v[k] = 1'b0;
      wait_idle(k);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comp_iter.md
Name: comp_iter

Overview:
- Parametrised, multi-cycle magnitude comparator; successor to the 16-bit combinational signed/unsigned comparator in the Comparison Unit.
- Compares two WIDTH-bit operands DIGIT bits per cycle, starting at the MSB chunk, and stops early on the first chunk that differs.
- Uses a start/ready input handshake and a one-cycle valid_out result strobe. Also returns the max and min operand, for use by the ALU sequencer and sort/select datapaths.

Parameters:
WIDTH  16  operand width in bits; must be a multiple of DIGIT
DIGIT  4   bits compared per cycle; N = WIDTH/DIGIT chunks (1 <= N)

Ports:
clk        input   1      system clock, all state updates on rising edge
rst        input   1      synchronous active-high reset
start      input   1      request; accepted only when ready=1
ready      output  1      1 when idle and able to accept start
in0        input   WIDTH  operand A, sampled on accept
in1        input   WIDTH  operand B, sampled on accept
is_signed  input   1      1 = two's-complement compare, 0 = unsigned; sampled on accept
valid_out  output  1      one-cycle strobe: result outputs updated
busy       output  1      1 while a comparison is in progress
GT         output  1      in0 > in1
LT         output  1      in0 < in1
ET         output  1      in0 == in1
max_out    output  WIDTH  larger operand (in0 when equal)
min_out    output  WIDTH  smaller operand (in1 when equal)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, valid_out=0, GT=LT=ET=0, max_out=min_out=0, chunk index=0.
- ready = (state==IDLE) && !rst, so ready is 0 while rst is high. busy = (state==BUSY).
- States:
  - IDLE: on start && ready, latch in0/in1/is_signed into operand registers, set idx=0, go to BUSY. Without start, stay in IDLE.
  - BUSY: each edge compares chunk idx, where idx 0 is the MSB chunk [WIDTH-1 -: DIGIT].
  - If the chunk of A differs from the chunk of B, or idx==N-1: write GT/LT/ET/max_out/min_out, set valid_out=1 for one cycle, go to IDLE.
  - Otherwise idx<=idx+1 and stay in BUSY.
- Signed mode: on latch, invert the sign bit (bit WIDTH-1) of both operands, then compare unsigned. Result is identical to the two's-complement order.
  - max_out/min_out always return the original, un-inverted operands.
- Latency: with start accepted at edge E, the result is written at edge E+1+j. j = index of the first differing chunk, or N-1 if the operands are equal.
  - Range is 1..N cycles in BUSY; valid_out is high during the cycle after the write edge.
- Exactly one of GT/LT/ET is 1 after any completed comparison. All result outputs hold their values until the next completion or reset.
- valid_out is 0 on every cycle except the one following a completion.
- ready returns to 1 in the same cycle valid_out is high. A start in that cycle is accepted (back-to-back operation), and results of the previous compare stay stable in that cycle.
- start while BUSY is ignored; no queuing, and operand inputs are don't-care.
- in0/in1/is_signed changing during BUSY has no effect; operands are registered.
- rst mid-comparison: abort, return to IDLE, clear all outputs to reset values, no valid_out.
- N==1 (DIGIT==WIDTH): every compare completes in exactly one BUSY cycle.
- WIDTH%DIGIT != 0 is illegal; elaboration must fail (generate-time check).

Test Plan:
- WIDTH=16, DIGIT=4, unsigned: in0=0x1234, in1=0x1234 -> 4 BUSY cycles, valid_out, ET=1, GT=LT=0, max_out=min_out=0x1234.
- Unsigned, in0=0x8000, in1=0x7FFF -> resolves on chunk 0 (1 BUSY cycle), GT=1, max_out=0x8000, min_out=0x7FFF. Signed, same operands -> LT=1, max_out=0x7FFF, min_out=0x8000.
- Signed, in0=0xFFFE (-2), in1=0xFFFF (-1) -> resolves on chunk 3 (4 cycles), LT=1, max_out=0xFFFF. Signed, 0x0000 vs 0xFFFF -> GT=1 on chunk 0.
- Back-to-back: start held high, vectors (5,3), (3,5), (7,7) with operands changed during BUSY -> three valid_out strobes with GT, LT, ET in order, using only the latched operands. No start is lost at a valid_out cycle.
- rst asserted on the 2nd BUSY cycle of 0x0001 vs 0x0002 -> no valid_out, all outputs 0, ready=1 the cycle after rst drops. A new compare then completes normally.
- Random sweep for WIDTH=16/DIGIT=4, WIDTH=32/DIGIT=8 and WIDTH=8/DIGIT=8 against a reference model, both signedness modes:
  - GT/LT/ET/max/min must match.
  - Latency must equal the first-differing-chunk index + 1.
